// File: rtl/servo_array.sv
// ============================================================================
// servo_array
//
// Multi-channel frame-based servo driver. Each channel tracks a target
// position (live inputs or a latched preset), slews toward it once per frame
// and emits a pulse of MIN_CYC + cur_pos*SCALE cycles at the start of every
// frame of PERIOD_CYC cycles.
//
// Configuration macro: SERVO_ARRAY_SLEW_EN
//   defined   : cur_pos moves at most STEP per frame, busy reports motion.
//   undefined : cur_pos jumps straight to the target, busy is constant 0.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          run enable; low forces the frame counter and pulses to 0
//   mode        0 = live targets, 1 = preset targets
//   live_pos    NCH*DW live positions, channel i at [i*DW +: DW]
//   preset_pos  NCH*DW preset positions, same packing
//   load        one-cycle strobe capturing preset_pos (mode = 1 only)
//   pwm_out     NCH servo pulses
//   cur_pos     NCH*DW current slewed positions
//   frame_tick  high during the last cycle of each frame
//   busy        high while any cur_pos differs from its target
//
// pwm_out is registered from the frame counter, so the pulse trails the
// counter by one cycle; every frame (including the first one after en rises)
// therefore carries a pulse of exactly pw cycles.
// ============================================================================
module servo_array #(
   parameter int NCH        = 3,
   parameter int DW         = 8,
   parameter int PERIOD_CYC = 1_000_000,
   parameter int MIN_CYC    = 50_000,
   parameter int SCALE      = 196,
   parameter int STEP       = 2,
   parameter int RESET_POS  = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [NCH*DW-1:0] live_pos,
   input  logic [NCH*DW-1:0] preset_pos,
   input  logic              load,
   output logic [NCH-1:0]    pwm_out,
   output logic [NCH*DW-1:0] cur_pos,
   output logic              frame_tick,
   output logic              busy
);

   localparam int            CW        = $clog2(PERIOD_CYC + 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(PERIOD_CYC - 1);
   localparam logic [CW-1:0] ONE_CNT   = CW'(1);
   localparam logic [DW-1:0] RESET_P   = DW'(RESET_POS);
   localparam logic [CW-1:0] PW_RESET  = CW'(MIN_CYC + RESET_POS * SCALE);

   // The widest pulse must end before the frame does, or pulses merge.
   if (MIN_CYC + ((2 ** DW) - 1) * SCALE >= PERIOD_CYC) begin : g_chk_range
      $fatal(1, "servo_array: MIN_CYC + (2^DW-1)*SCALE must be < PERIOD_CYC");
   end

   // A zero step would freeze every channel forever.
   if (STEP < 1) begin : g_chk_step
      $fatal(1, "servo_array: STEP must be at least 1");
   end

   // Pulse width for a given position.
   function automatic logic [CW-1:0] pw_of(input logic [DW-1:0] p);
      return CW'(MIN_CYC) + CW'(p) * CW'(SCALE);
   endfunction

`ifdef SERVO_ARRAY_SLEW_EN
   localparam logic [DW-1:0] STEP_V = DW'(STEP);

   // One slew step toward tgt; differences are formed only in the
   // direction that cannot underflow, and the last step lands exactly.
   function automatic logic [DW-1:0] slew(input logic [DW-1:0] cur,
                                          input logic [DW-1:0] tgt);
      logic [DW-1:0] res;
      if (tgt > cur) begin
         if ((tgt - cur) > STEP_V) begin
            res = cur + STEP_V;
         end else begin
            res = tgt;
         end
      end else if (cur > tgt) begin
         if ((cur - tgt) > STEP_V) begin
            res = cur - STEP_V;
         end else begin
            res = tgt;
         end
      end else begin
         res = tgt;
      end
      return res;
   endfunction
`endif

   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [NCH-1:0] pwm_q,   pwm_d;
   logic           tick_q,  tick_d;
   logic           busy_q,  busy_d;
   logic [DW-1:0]  cur_q    [NCH];
   logic [DW-1:0]  cur_d    [NCH];
   logic [DW-1:0]  tgt_q    [NCH];
   logic [DW-1:0]  tgt_d    [NCH];
   logic [CW-1:0]  pw_q     [NCH];
   logic [CW-1:0]  pw_d     [NCH];
   logic           frame_end_s;

   assign frame_end_s = en && (cnt_q == LAST_CNT);

   // Next-state logic: frame counter, targets, slew, pulse widths, outputs.
   always_comb begin
      cnt_d  = cnt_q;
      pwm_d  = '0;
      tick_d = 1'b0;
      busy_d = 1'b0;
      cur_d  = cur_q;
      tgt_d  = tgt_q;
      pw_d   = pw_q;

      if (!en) begin
         cnt_d = '0;
      end else if (frame_end_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE_CNT;
      end

      // Registered so that it is high while the counter sits on its last value.
      tick_d = en && (cnt_d == LAST_CNT);

      for (int i = 0; i < NCH; i++) begin
         pwm_d[i] = en && (cnt_q < pw_q[i]);

         // Load and live capture are exclusive by mode, so a load on the
         // frame-end cycle is already in tgt_d when the slew step reads it.
         if (en && mode && load) begin
            tgt_d[i] = preset_pos[i*DW +: DW];
         end else if (frame_end_s && !mode) begin
            tgt_d[i] = live_pos[i*DW +: DW];
         end else begin
            tgt_d[i] = tgt_q[i];
         end

         if (frame_end_s) begin
`ifdef SERVO_ARRAY_SLEW_EN
            cur_d[i] = slew(cur_q[i], tgt_d[i]);
`else
            cur_d[i] = tgt_d[i];
`endif
            pw_d[i]  = pw_of(cur_d[i]);
         end else begin
            cur_d[i] = cur_q[i];
            pw_d[i]  = pw_q[i];
         end

`ifdef SERVO_ARRAY_SLEW_EN
         busy_d = busy_d | (cur_d[i] != tgt_d[i]);
`else
         busy_d = 1'b0;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pwm_q  <= '0;
         tick_q <= 1'b0;
         busy_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cur_q[i] <= RESET_P;
            tgt_q[i] <= RESET_P;
            pw_q[i]  <= PW_RESET;
         end
      end else begin
         cnt_q  <= cnt_d;
         pwm_q  <= pwm_d;
         tick_q <= tick_d;
         busy_q <= busy_d;
         cur_q  <= cur_d;
         tgt_q  <= tgt_d;
         pw_q   <= pw_d;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_pack
      assign cur_pos[g*DW +: DW] = cur_q[g];
   end

   assign pwm_out    = pwm_q;
   assign frame_tick = tick_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_servo_array.sv
// ============================================================================
// tb_servo_array
//
// Directed bench for servo_array (NCH=3, DW=8, PERIOD_CYC=1000, MIN_CYC=50,
// SCALE=2, STEP=4, RESET_POS=128). Before each frame the expected pulse
// widths, post-frame positions and busy flag are pushed into a scoreboard;
// after the frame has been observed the entry is popped and compared.
// ============================================================================
module tb_servo_array;

   localparam int NCH    = 3;
   localparam int DW     = 8;
   localparam int PERIOD = 1000;
   localparam int MINC   = 50;
   localparam int SCALE  = 2;
   localparam int STEP   = 4;
   localparam int RPOS   = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              mode;
   logic [NCH*DW-1:0] live_pos;
   logic [NCH*DW-1:0] preset_pos;
   logic              load;
   logic [NCH-1:0]    pwm_out;
   logic [NCH*DW-1:0] cur_pos;
   logic              frame_tick;
   logic              busy;

   servo_array #(
      .NCH(NCH), .DW(DW), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC),
      .SCALE(SCALE), .STEP(STEP), .RESET_POS(RPOS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
      .live_pos(live_pos), .preset_pos(preset_pos), .load(load),
      .pwm_out(pwm_out), .cur_pos(cur_pos),
      .frame_tick(frame_tick), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          pw0;
      int          pw1;
      int          pw2;
      logic [23:0] cur;
      logic        bsy;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int m_cur[3];
   int m_tgt[3];
   int l_val[3];
   int p_val[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int step_to(input int c, input int t);
`ifdef SERVO_ARRAY_SLEW_EN
      if (t - c > STEP) return c + STEP;
      if (c - t > STEP) return c - STEP;
      return t;
`else
      return t + 0 * c;
`endif
   endfunction

   function automatic logic model_busy();
`ifdef SERVO_ARRAY_SLEW_EN
      return (m_cur[0] != m_tgt[0]) || (m_cur[1] != m_tgt[1]) || (m_cur[2] != m_tgt[2]);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [23:0] model_cur();
      return {8'(m_cur[2]), 8'(m_cur[1]), 8'(m_cur[0])};
   endfunction

   task automatic drive_inputs();
      live_pos   = {8'(l_val[2]), 8'(l_val[1]), 8'(l_val[0])};
      preset_pos = {8'(p_val[2]), 8'(p_val[1]), 8'(p_val[0])};
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cur[k] = RPOS;
         m_tgt[k] = RPOS;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One full frame starting from cnt=0; load_at>0 strobes load so that it
   // is sampled on edge load_at+1 (load_at=999 hits the frame-end edge).
   task automatic run_frame(input string tag, input int load_at);
      exp_t        e;
      exp_t        g;
      int          hi0, hi1, hi2, tick_n, tick_at;
      logic [2:0]  first;
      drive_inputs();
      e.pw0 = MINC + m_cur[0] * SCALE;
      e.pw1 = MINC + m_cur[1] * SCALE;
      e.pw2 = MINC + m_cur[2] * SCALE;
      if (load_at > 0 && mode) begin
         for (int k = 0; k < 3; k++) m_tgt[k] = p_val[k];
      end
      if (!mode) begin
         for (int k = 0; k < 3; k++) m_tgt[k] = l_val[k];
      end
      for (int k = 0; k < 3; k++) m_cur[k] = step_to(m_cur[k], m_tgt[k]);
      e.cur = model_cur();
      e.bsy = model_busy();
      sb.push_back(e);

      hi0 = 0; hi1 = 0; hi2 = 0; tick_n = 0; tick_at = -1; first = 3'b000;
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk);
         if (i == 1) first = pwm_out;
         hi0 += int'(pwm_out[0]);
         hi1 += int'(pwm_out[1]);
         hi2 += int'(pwm_out[2]);
         if (frame_tick) begin
            tick_n++;
            tick_at = i;
         end
         load = (i == load_at) ? 1'b1 : 1'b0;
      end
      load = 1'b0;

      g = sb.pop_front();
      check({tag, " pulse_start"}, 32'(first), 32'd7);
      check({tag, " pw0"}, hi0, g.pw0);
      check({tag, " pw1"}, hi1, g.pw1);
      check({tag, " pw2"}, hi2, g.pw2);
      check({tag, " tick_count"}, tick_n, 1);
      check({tag, " tick_pos"}, tick_at, PERIOD - 1);
      check({tag, " cur_pos"}, 32'(cur_pos), 32'(g.cur));
      check({tag, " busy"}, 32'(busy), 32'(g.bsy));
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      mode  = 1'b0;
      load  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         l_val[k] = RPOS;
         p_val[k] = RPOS;
      end
      drive_inputs();
      model_reset();

      // Reset values, then idle with en low.
      run_cycles(3);
      check("rst cur_pos", 32'(cur_pos), 32'h808080);
      check("rst pwm", 32'(pwm_out), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      run_cycles(20);
      check("idle pwm", 32'(pwm_out), 32'd0);
      check("idle tick", 32'(frame_tick), 32'd0);
      check("idle cur_pos", 32'(cur_pos), 32'h808080);

      // 1: centred positions, 306-cycle pulses.
      en = 1'b1;
      run_frame("t1", 0);

      // 2: live ch0 -> 200, 18 frames of slew then a 450-cycle pulse.
      l_val[0] = 200;
      for (int f = 0; f < 19; f++) run_frame($sformatf("t2 f%0d", f), 0);

      // 3: preset ch1 -> 0 with one load; live and matching presets ignored.
      mode     = 1'b1;
      p_val[0] = 200;
      p_val[1] = 0;
      p_val[2] = 128;
      l_val[0] = 17;
      l_val[1] = 250;
      l_val[2] = 3;
      run_frame("t3 load", 500);
      for (int f = 1; f < 33; f++) begin
         l_val[f % 3] = $urandom_range(0, 255);
         run_frame($sformatf("t3 f%0d", f), 0);
      end

      // 4: overshoot guard, then load on the frame-end cycle.
      p_val[2] = 130;
      run_frame("t4 guard", 10);
      p_val[2] = 100;
      run_frame("t4 endload", 999);
      // Back to live: targets overwritten at the next frame end.
      mode     = 1'b0;
      l_val[0] = 200;
      l_val[1] = 0;
      l_val[2] = 110;
      run_frame("t4 live", 0);

      // 5: drop en at cnt=100 mid-slew, hold, re-enable.
      drive_inputs();
      run_cycles(100);
      en = 1'b0;
      @(negedge clk);
      check("t5 pwm_off", 32'(pwm_out), 32'd0);
      check("t5 tick_off", 32'(frame_tick), 32'd0);
      check("t5 cur_held", 32'(cur_pos), 32'(model_cur()));
      run_cycles(50);
      check("t5 pwm_still_off", 32'(pwm_out), 32'd0);
      check("t5 cur_still_held", 32'(cur_pos), 32'(model_cur()));
      check("t5 busy_held", 32'(busy), 32'(model_busy()));
      en = 1'b1;
      run_frame("t5 resume", 0);

      // 6: asynchronous reset at cnt=500 mid-slew.
      run_cycles(500);
      check("t6 busy_before", 32'(busy), 32'(model_busy()));
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 rst cur_pos", 32'(cur_pos), 32'h808080);
      check("t6 rst pwm", 32'(pwm_out), 32'd0);
      check("t6 rst busy", 32'(busy), 32'd0);
      check("t6 rst tick", 32'(frame_tick), 32'd0);
      model_reset();
      l_val[0] = 128;
      l_val[1] = 128;
      l_val[2] = 140;
      drive_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      run_frame("t6 f0", 0);
      run_frame("t6 f1", 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
